// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte-framing stage.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } frame_state_t;

    localparam logic [1:0] FRAME_OK          = 2'd0;
    localparam logic [1:0] FRAME_ERR_CSUM    = 2'd1;
    localparam logic [1:0] FRAME_ERR_LEN     = 2'd2;
    localparam logic [1:0] FRAME_ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Frame checksum accumulates modulo 256; carries are dropped.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap down-counter; flags expiry when the line stays silent too long mid-frame.
module uart_gap_timer #(
    parameter int RELOAD = 2080,
    parameter int WIDTH  = $clog2(RELOAD) + 1
) (
    input  logic uart_clk,
    input  logic reset,
    input  logic reload,
    input  logic enable,
    output logic expired
);

    // The strobe cycle itself is the first cycle of the gap, hence RELOAD-1.
    localparam logic [WIDTH-1:0] LOAD_VALUE = WIDTH'(RELOAD - 1);
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO       = {WIDTH{1'b0}};

    logic [WIDTH-1:0] count_r;

    // Reload on every byte, count down while a frame is open.
    always_ff @(posedge uart_clk) begin
        if (reset) begin
            count_r <= ZERO;
        end else if (reload) begin
            count_r <= LOAD_VALUE;
        end else if (enable && (count_r != ZERO)) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // A same-cycle strobe always wins over expiry.
    assign expired = enable && !reload && (count_r == ONE);

endmodule

// File: rtl/uart_frame_decoder.sv
// Frame locator downstream of the UART receiver: SYNC, LEN, payload, CHECK.
module uart_frame_decoder
    import uart_pkg::*;
#(
    parameter int         CLOCK_FREQUENCY = 12_000_000,
    parameter int         BAUD_RATE       = 115_200,
    parameter logic [7:0] SYNC_BYTE       = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN         = 16,
    parameter int         TIMEOUT_BAUDS   = 20
) (
    input  logic       uart_clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    output logic [7:0] payload_data,
    output logic       payload_valid,
    output logic       payload_last,
    output logic       frame_done,
    output logic [1:0] frame_status,
    output logic [7:0] frame_len,
    output logic [7:0] sync_miss_count
);

    localparam int         TIMEOUT_RELOAD = TIMEOUT_BAUDS * (CLOCK_FREQUENCY / BAUD_RATE);
    localparam logic [7:0] MAX_LEN_BYTE   = 8'(MAX_LEN);

    frame_state_t state_r;
    logic [7:0]   sum_r;
    logic [7:0]   count_r;
    logic         timer_enable_s;
    logic         timer_expired_s;

    assign timer_enable_s = (state_r != IDLE);

    uart_gap_timer #(
        .RELOAD (TIMEOUT_RELOAD)
    ) u_gap_timer (
        .uart_clk (uart_clk),
        .reset    (reset),
        .reload   (rx_strobe),
        .enable   (timer_enable_s),
        .expired  (timer_expired_s)
    );

    // Frame FSM with registered payload and status outputs.
    always_ff @(posedge uart_clk) begin
        if (reset) begin
            state_r         <= IDLE;
            sum_r           <= 8'd0;
            count_r         <= 8'd0;
            payload_data    <= 8'd0;
            payload_valid   <= 1'b0;
            payload_last    <= 1'b0;
            frame_done      <= 1'b0;
            frame_status    <= FRAME_OK;
            frame_len       <= 8'd0;
            sync_miss_count <= 8'd0;
        end else begin
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            frame_done    <= 1'b0;
            if (rx_strobe) begin
                case (state_r)
                    IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_r <= LEN;
                        end else if (sync_miss_count != 8'hFF) begin
                            sync_miss_count <= sync_miss_count + 8'd1;
                        end else begin
                            sync_miss_count <= sync_miss_count;
                        end
                    end
                    LEN: begin
                        frame_len <= rx_data;
                        sum_r     <= rx_data;
                        if (rx_data > MAX_LEN_BYTE) begin
                            frame_done   <= 1'b1;
                            frame_status <= FRAME_ERR_LEN;
                            state_r      <= IDLE;
                        end else if (rx_data == 8'd0) begin
                            state_r <= CHECK;
                        end else begin
                            count_r <= rx_data;
                            state_r <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        payload_data  <= rx_data;
                        payload_valid <= 1'b1;
                        sum_r         <= csum_add(sum_r, rx_data);
                        count_r       <= count_r - 8'd1;
                        if (count_r == 8'd1) begin
                            payload_last <= 1'b1;
                            state_r      <= CHECK;
                        end else begin
                            state_r <= PAYLOAD;
                        end
                    end
                    CHECK: begin
                        frame_done   <= 1'b1;
                        frame_status <= (rx_data == sum_r) ? FRAME_OK : FRAME_ERR_CSUM;
                        state_r      <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end else if (timer_expired_s) begin
                frame_done   <= 1'b1;
                frame_status <= FRAME_ERR_TIMEOUT;
                state_r      <= IDLE;
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench: directed frames plus a random byte stream against a frame-parsing model.
module tb_uart_frame_decoder;

    localparam int MAX_LEN = 16;

    logic       uart_clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic [7:0] payload_data;
    logic       payload_valid;
    logic       payload_last;
    logic       frame_done;
    logic [1:0] frame_status;
    logic [7:0] frame_len;
    logic [7:0] sync_miss_count;

    int tests = 0;
    int fails = 0;

    logic [7:0] obs_pay[$];
    logic       obs_last[$];
    logic [1:0] obs_st[$];
    int         overlap = 0;
    int         stray_last = 0;

    logic [7:0] stream_q[$];
    logic [7:0] exp_pay[$];
    logic       exp_last[$];
    logic [1:0] exp_st[$];
    int         exp_miss;
    logic [7:0] exp_len;

    always #5 uart_clk = ~uart_clk;

    uart_frame_decoder #(.MAX_LEN(MAX_LEN)) dut (
        .uart_clk        (uart_clk),
        .reset           (reset),
        .rx_data         (rx_data),
        .rx_strobe       (rx_strobe),
        .payload_data    (payload_data),
        .payload_valid   (payload_valid),
        .payload_last    (payload_last),
        .frame_done      (frame_done),
        .frame_status    (frame_status),
        .frame_len       (frame_len),
        .sync_miss_count (sync_miss_count)
    );

    always @(negedge uart_clk) begin
        if (payload_valid) begin
            obs_pay.push_back(payload_data);
            obs_last.push_back(payload_last);
        end
        if (frame_done) obs_st.push_back(frame_status);
        if (payload_valid && frame_done) overlap++;
        if (payload_last && !payload_valid) stray_last++;
    end

    task automatic send(input logic [7:0] b);
        rx_data   = b;
        rx_strobe = 1'b1;
        stream_q.push_back(b);
        @(negedge uart_clk);
        rx_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge uart_clk);
    endtask

    task automatic gap();
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        rx_strobe = 1'b0;
        rx_data   = 8'd0;
        repeat (2) @(negedge uart_clk);
        reset = 1'b0;
        obs_pay.delete();
        obs_last.delete();
        obs_st.delete();
        stream_q.delete();
    endtask

    // Reference: parse the byte stream frame by frame from the framing rules.
    task automatic model_parse();
        int i, n, len, sum;
        exp_pay.delete(); exp_last.delete(); exp_st.delete();
        exp_miss = 0;
        exp_len  = 8'd0;
        i = 0;
        n = stream_q.size();
        while (i < n) begin
            if (stream_q[i] != 8'hA5) begin
                if (exp_miss < 255) exp_miss++;
                i++;
            end else if (i + 1 >= n) begin
                exp_st.push_back(2'd3);
                i = n;
            end else begin
                len     = int'(stream_q[i+1]);
                exp_len = stream_q[i+1];
                if (len > MAX_LEN) begin
                    exp_st.push_back(2'd2);
                    i += 2;
                end else begin
                    sum = len;
                    for (int k = 0; k < len; k++) begin
                        if (i + 2 + k < n) begin
                            exp_pay.push_back(stream_q[i+2+k]);
                            exp_last.push_back(k == len - 1);
                            sum += int'(stream_q[i+2+k]);
                        end
                    end
                    if (i + 2 + len < n) begin
                        exp_st.push_back((int'(stream_q[i+2+len]) == sum % 256) ? 2'd0 : 2'd1);
                        i += 3 + len;
                    end else begin
                        exp_st.push_back(2'd3);
                        i = n;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if ({payload_data, payload_valid, payload_last, frame_done, frame_status, frame_len, sync_miss_count} !== 29'd0) begin
            fails++;
            $display("FAIL reset_values: got pd=%h pv=%b pl=%b fd=%b fs=%0d fl=%h sm=%0d expected all 0",
                     payload_data, payload_valid, payload_last, frame_done, frame_status, frame_len, sync_miss_count);
        end
    endtask

    task automatic test_ok_frame();
        logic [7:0] exp_p[3];
        exp_p[0] = 8'h11; exp_p[1] = 8'h22; exp_p[2] = 8'h33;
        apply_reset();
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
        idle(2);
        tests++;
        if (obs_pay.size() != 3 || obs_st.size() != 1) begin
            fails++;
            $display("FAIL ok_counts: got %0d payload/%0d done expected 3/1", obs_pay.size(), obs_st.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (obs_pay[i] !== exp_p[i] || obs_last[i] !== (i == 2)) begin
                    fails++;
                    $display("FAIL ok_pay[%0d]: got %h/%b expected %h/%b", i, obs_pay[i], obs_last[i], exp_p[i], i == 2);
                end
            end
            tests++;
            if (obs_st[0] !== 2'd0) begin
                fails++;
                $display("FAIL ok_status: got %0d expected 0", obs_st[0]);
            end
        end
        tests++;
        if (frame_len !== 8'h03) begin
            fails++;
            $display("FAIL ok_len: got %h expected 03", frame_len);
        end
    endtask

    task automatic test_csum_error();
        apply_reset();
        send(8'hA5); send(8'h02); send(8'hFF); send(8'h02); send(8'h00);
        idle(2);
        tests++;
        if (obs_pay.size() != 2 || obs_st.size() != 1) begin
            fails++;
            $display("FAIL csum_counts: got %0d payload/%0d done expected 2/1", obs_pay.size(), obs_st.size());
        end else begin
            tests++;
            if (obs_pay[0] !== 8'hFF || obs_pay[1] !== 8'h02 || obs_last[1] !== 1'b1) begin
                fails++;
                $display("FAIL csum_pay: got %h %h last=%b expected ff 02 last=1", obs_pay[0], obs_pay[1], obs_last[1]);
            end
            tests++;
            if (obs_st[0] !== 2'd1) begin
                fails++;
                $display("FAIL csum_status: got %0d expected 1", obs_st[0]);
            end
        end
    endtask

    task automatic test_len_error();
        int sum;
        apply_reset();
        send(8'hA5); send(8'h11);
        idle(2);
        tests++;
        if (obs_pay.size() != 0 || obs_st.size() != 1 || obs_st[0] !== 2'd2) begin
            fails++;
            $display("FAIL len_reject: got %0d payload/%0d done expected 0 payload, one done status 2", obs_pay.size(), obs_st.size());
        end
        tests++;
        if (frame_len !== 8'h11) begin
            fails++;
            $display("FAIL len_reject_len: got %h expected 11", frame_len);
        end
        // MAX_LEN itself is a legal length.
        send(8'hA5); send(8'h10);
        sum = 16;
        for (int i = 0; i < 16; i++) begin
            send(8'(i * 37 + 5));
            sum += (i * 37 + 5) % 256;
        end
        send(8'(sum % 256));
        idle(2);
        tests++;
        if (obs_pay.size() != 16 || obs_st.size() != 2) begin
            fails++;
            $display("FAIL len_max_counts: got %0d payload/%0d done expected 16/2", obs_pay.size(), obs_st.size());
        end else begin
            tests++;
            if (obs_st[1] !== 2'd0 || obs_last[15] !== 1'b1 || obs_last[14] !== 1'b0 || obs_pay[15] !== 8'(15 * 37 + 5)) begin
                fails++;
                $display("FAIL len_max_frame: got status %0d last15=%b last14=%b pay15=%h expected 0 1 0 %h",
                         obs_st[1], obs_last[15], obs_last[14], obs_pay[15], 8'(15 * 37 + 5));
            end
        end
    endtask

    task automatic test_timeout();
        int found;
        apply_reset();
        send(8'hA5); send(8'h02); send(8'h44);
        found = -1;
        for (int k = 1; k <= 2200; k++) begin
            @(negedge uart_clk);
            if (frame_done && found < 0) found = k;
        end
        tests++;
        if (found != 2079 || obs_st.size() != 1 || obs_st[0] !== 2'd3) begin
            fails++;
            $display("FAIL timeout_exact: got done after %0d edges (%0d dones) expected 2079 edges, status 3", found, obs_st.size());
        end
        obs_st.delete();
        obs_pay.delete();
        obs_last.delete();
        send(8'hA5); send(8'h02); send(8'h44);
        idle(2078);
        send(8'h55);
        idle(2);
        send(8'h9B);
        idle(2);
        tests++;
        if (obs_st.size() != 1 || obs_st[0] !== 2'd0 || obs_pay.size() != 2) begin
            fails++;
            $display("FAIL timeout_prevent: got %0d done/%0d payload expected one done status 0, 2 payload", obs_st.size(), obs_pay.size());
        end
    endtask

    task automatic test_sync_miss();
        apply_reset();
        for (int i = 0; i < 5; i++) send(8'h00);
        tests++;
        if (sync_miss_count !== 8'd5) begin
            fails++;
            $display("FAIL miss_count5: got %0d expected 5", sync_miss_count);
        end
        for (int i = 0; i < 295; i++) send(8'h00);
        tests++;
        if (sync_miss_count !== 8'd255) begin
            fails++;
            $display("FAIL miss_saturate: got %0d expected 255", sync_miss_count);
        end
        send(8'hA5); send(8'h00); send(8'h00);
        idle(2);
        tests++;
        if (obs_pay.size() != 0 || obs_st.size() != 1 || obs_st[0] !== 2'd0 || frame_len !== 8'h00 || sync_miss_count !== 8'd255) begin
            fails++;
            $display("FAIL zero_len: got %0d payload/%0d done len=%h miss=%0d expected 0/1 status 0 len 00 miss 255",
                     obs_pay.size(), obs_st.size(), frame_len, sync_miss_count);
        end
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        send(8'hA5); send(8'h03); send(8'h11);
        reset = 1'b1;
        @(negedge uart_clk);
        tests++;
        if ({payload_data, payload_valid, payload_last, frame_done, frame_status, frame_len, sync_miss_count} !== 29'd0) begin
            fails++;
            $display("FAIL midframe_reset: got pd=%h pv=%b fd=%b fl=%h expected all 0", payload_data, payload_valid, frame_done, frame_len);
        end
        reset = 1'b0;
        obs_pay.delete(); obs_last.delete(); obs_st.delete();
        send(8'h22);
        send(8'hA5); send(8'h01); send(8'hA5); send(8'hA6);
        idle(2);
        tests++;
        if (obs_pay.size() != 1 || obs_st.size() != 1 || sync_miss_count !== 8'd1) begin
            fails++;
            $display("FAIL back_to_back_counts: got %0d payload/%0d done miss=%0d expected 1/1 miss 1", obs_pay.size(), obs_st.size(), sync_miss_count);
        end else begin
            tests++;
            if (obs_pay[0] !== 8'hA5 || obs_last[0] !== 1'b1 || obs_st[0] !== 2'd0) begin
                fails++;
                $display("FAIL back_to_back: got %h/%b status %0d expected a5/1 status 0", obs_pay[0], obs_last[0], obs_st[0]);
            end
        end
    endtask

    task automatic test_random_stream();
        int         len, sum;
        logic [7:0] b;
        apply_reset();
        for (int f = 0; f < 25; f++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                send(b);
                gap();
            end
            send(8'hA5); gap();
            len = $urandom_range(0, MAX_LEN + 2);
            send(8'(len)); gap();
            if (len <= MAX_LEN) begin
                sum = len;
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom_range(0, 255));
                    sum += int'(b);
                    send(b);
                    gap();
                end
                b = 8'(sum % 256);
                if ($urandom_range(0, 3) == 0) b = b ^ 8'(1 << $urandom_range(0, 7));
                send(b);
                gap();
            end
        end
        if ($urandom_range(0, 1) == 1) begin
            send(8'hA5); send(8'h03); send(8'($urandom_range(0, 255)));
        end
        idle(2200);
        model_parse();
        tests++;
        if (obs_pay.size() != exp_pay.size() || obs_st.size() != exp_st.size()) begin
            fails++;
            $display("FAIL rand_counts: got %0d payload/%0d done expected %0d/%0d",
                     obs_pay.size(), obs_st.size(), exp_pay.size(), exp_st.size());
        end else begin
            for (int i = 0; i < exp_pay.size(); i++) begin
                tests++;
                if (obs_pay[i] !== exp_pay[i] || obs_last[i] !== exp_last[i]) begin
                    fails++;
                    $display("FAIL rand_pay[%0d]: got %h/%b expected %h/%b", i, obs_pay[i], obs_last[i], exp_pay[i], exp_last[i]);
                end
            end
            for (int i = 0; i < exp_st.size(); i++) begin
                tests++;
                if (obs_st[i] !== exp_st[i]) begin
                    fails++;
                    $display("FAIL rand_status[%0d]: got %0d expected %0d", i, obs_st[i], exp_st[i]);
                end
            end
        end
        tests++;
        if (sync_miss_count !== 8'(exp_miss) || frame_len !== exp_len) begin
            fails++;
            $display("FAIL rand_counters: got miss=%0d len=%h expected miss=%0d len=%h", sync_miss_count, frame_len, exp_miss, exp_len);
        end
        tests++;
        if (overlap != 0 || stray_last != 0) begin
            fails++;
            $display("FAIL pulse_rules: got %0d done/valid overlaps, %0d stray last expected 0/0", overlap, stray_last);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        rx_strobe = 1'b0;
        rx_data   = 8'd0;
        test_reset();
        test_ok_frame();
        test_csum_error();
        test_len_error();
        test_timeout();
        test_sync_miss();
        test_reset_midframe();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
